// File: rtl/spi_master_buffer_if.sv
// Bus between the SPI master buffer and its controller: TX queue writes, shift-register
// load strobes, and the RX queue read side.
interface spi_master_buffer_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0] i_TX_Data;
  logic              i_TX_Write;
  logic              o_TX_Full;
  logic [CNT_W-1:0]  o_TX_Count;
  logic [DATA_W-1:0] o_SR_Data;
  logic              o_New_Data;
  logic              i_LD_SR;
  logic              i_LD_R;
  logic [DATA_W-1:0] i_RX_SR_Data;
  logic [DATA_W-1:0] o_RX_Data;
  logic              o_RX_Empty;
  logic              i_RX_Read;
  logic              o_TX_Overflow;
  logic              o_RX_Overflow;
  logic              i_Clr_Err;

  modport slave (
    input  i_TX_Data, i_TX_Write, i_LD_SR, i_LD_R, i_RX_SR_Data, i_RX_Read, i_Clr_Err,
    output o_TX_Full, o_TX_Count, o_SR_Data, o_New_Data, o_RX_Data, o_RX_Empty,
           o_TX_Overflow, o_RX_Overflow
  );

  modport master (
    output i_TX_Data, i_TX_Write, i_LD_SR, i_LD_R, i_RX_SR_Data, i_RX_Read, i_Clr_Err,
    input  o_TX_Full, o_TX_Count, o_SR_Data, o_New_Data, o_RX_Data, o_RX_Empty,
           o_TX_Overflow, o_RX_Overflow
  );
endinterface

// File: rtl/spi_master_buffer.sv
// TX/RX word FIFOs around an SPI master shift register. TX pops on the falling edge of the
// shift-register load level, RX captures on the rising edge of the receive load level.
module spi_master_buffer #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input logic             i_clk,
  input logic             i_rst,
  spi_master_buffer_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_W-1:0] tx_mem [DEPTH];
  logic [DATA_W-1:0] rx_mem [DEPTH];
  logic [PTR_W-1:0]  tx_rd_ptr, tx_wr_ptr, rx_rd_ptr, rx_wr_ptr;
  logic [CNT_W-1:0]  tx_cnt, rx_cnt;
  logic              primed, ld_sr_q, ld_r_q, tx_ovf, rx_ovf;
  logic              tx_full, tx_empty, rx_full, rx_empty;
  logic              tx_push, tx_pop, rx_push, rx_pop, rx_cap;
  logic              tx_ovf_set, rx_ovf_set;

  assign tx_full  = (tx_cnt == FULL_CNT);
  assign tx_empty = (tx_cnt == '0);
  assign rx_full  = (rx_cnt == FULL_CNT);
  assign rx_empty = (rx_cnt == '0);

  // primed stays low for the first clock after reset so a level already high
  // (or already low) at release is never mistaken for an edge.
  assign tx_pop     = primed & ld_sr_q & ~bus.i_LD_SR & ~tx_empty;
  assign tx_push    = bus.i_TX_Write & ~tx_full;
  assign tx_ovf_set = bus.i_TX_Write & tx_full;

  assign rx_cap     = primed & ~ld_r_q & bus.i_LD_R;
  assign rx_pop     = bus.i_RX_Read & ~rx_empty;
  assign rx_push    = rx_cap & (~rx_full | rx_pop);
  assign rx_ovf_set = rx_cap & rx_full & ~rx_pop;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      primed    <= 1'b0;
      ld_sr_q   <= 1'b0;
      ld_r_q    <= 1'b0;
      tx_rd_ptr <= '0;
      tx_wr_ptr <= '0;
      tx_cnt    <= '0;
      rx_rd_ptr <= '0;
      rx_wr_ptr <= '0;
      rx_cnt    <= '0;
      tx_ovf    <= 1'b0;
      rx_ovf    <= 1'b0;
    end else begin
      primed  <= 1'b1;
      ld_sr_q <= bus.i_LD_SR;
      ld_r_q  <= bus.i_LD_R;
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
      tx_cnt <= tx_cnt + CNT_W'(tx_push) - CNT_W'(tx_pop);
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
      rx_cnt <= rx_cnt + CNT_W'(rx_push) - CNT_W'(rx_pop);
      // set beats clear when both happen in one cycle
      tx_ovf <= tx_ovf_set | (tx_ovf & ~bus.i_Clr_Err);
      rx_ovf <= rx_ovf_set | (rx_ovf & ~bus.i_Clr_Err);
    end
  end

  // Storage is deliberately not reset; contents are don't-care while empty.
  always_ff @(posedge i_clk) begin
    if (tx_push) tx_mem[tx_wr_ptr] <= bus.i_TX_Data;
    if (rx_push) rx_mem[rx_wr_ptr] <= bus.i_RX_SR_Data;
  end

  assign bus.o_TX_Full     = tx_full;
  assign bus.o_TX_Count    = tx_cnt;
  assign bus.o_SR_Data     = tx_mem[tx_rd_ptr];
  assign bus.o_New_Data    = ~tx_empty;
  assign bus.o_RX_Data     = rx_mem[rx_rd_ptr];
  assign bus.o_RX_Empty    = rx_empty;
  assign bus.o_TX_Overflow = tx_ovf;
  assign bus.o_RX_Overflow = rx_ovf;
endmodule

// File: tb/tb_spi_master_buffer.sv
// Randomized and directed bench for spi_master_buffer against a queue-based model.
module tb_spi_master_buffer;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  spi_master_buffer_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();
  spi_master_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [DATA_W-1:0] tq[$];
  logic [DATA_W-1:0] rq[$];
  bit m_primed, m_prev_sr, m_prev_r, m_txo, m_rxo;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    tq.delete();
    rq.delete();
    m_primed  = 0;
    m_prev_sr = 0;
    m_prev_r  = 0;
    m_txo     = 0;
    m_rxo     = 0;
  endtask

  // One clock of the buffer's behaviour, from the values on the bus at the edge.
  task automatic model_step();
    bit tx_full, pop, wr, rx_full, cap, rd, tx_set, rx_set;
    tx_full = (tq.size() == DEPTH);
    pop     = m_primed && m_prev_sr && !bus.i_LD_SR && (tq.size() != 0);
    wr      = bus.i_TX_Write && !tx_full;
    tx_set  = bus.i_TX_Write && tx_full;
    rx_full = (rq.size() == DEPTH);
    cap     = m_primed && !m_prev_r && bus.i_LD_R;
    rd      = bus.i_RX_Read && (rq.size() != 0);
    rx_set  = cap && rx_full && !rd;
    if (pop) void'(tq.pop_front());
    if (wr)  tq.push_back(bus.i_TX_Data);
    if (rd)  void'(rq.pop_front());
    if (cap && !rx_set) rq.push_back(bus.i_RX_SR_Data);
    m_txo     = tx_set ? 1'b1 : (bus.i_Clr_Err ? 1'b0 : m_txo);
    m_rxo     = rx_set ? 1'b1 : (bus.i_Clr_Err ? 1'b0 : m_rxo);
    m_prev_sr = bus.i_LD_SR;
    m_prev_r  = bus.i_LD_R;
    m_primed  = 1;
  endtask

  task automatic check_outputs();
    chk("tx_count", 32'(bus.o_TX_Count), 32'(tq.size()));
    chk("tx_full", 32'(bus.o_TX_Full), 32'(tq.size() == DEPTH));
    chk("new_data", 32'(bus.o_New_Data), 32'(tq.size() != 0));
    chk("rx_empty", 32'(bus.o_RX_Empty), 32'(rq.size() == 0));
    chk("tx_ovf", 32'(bus.o_TX_Overflow), 32'(m_txo));
    chk("rx_ovf", 32'(bus.o_RX_Overflow), 32'(m_rxo));
    if (tq.size() != 0) chk("sr_data", 32'(bus.o_SR_Data), 32'(tq[0]));
    if (rq.size() != 0) chk("rx_data", 32'(bus.o_RX_Data), 32'(rq[0]));
  endtask

  // Called at a falling edge; strobes last one cycle, levels persist.
  task automatic tick(bit wr = 0, logic [DATA_W-1:0] d = '0, bit rd = 0, bit clr = 0);
    bus.i_TX_Write = wr;
    bus.i_TX_Data  = d;
    bus.i_RX_Read  = rd;
    bus.i_Clr_Err  = clr;
    @(posedge clk);
    model_step();
    @(negedge clk);
    bus.i_TX_Write = 0;
    bus.i_RX_Read  = 0;
    bus.i_Clr_Err  = 0;
    check_outputs();
  endtask

  task automatic check_reset_values(string tag);
    chk({tag, "_count"}, 32'(bus.o_TX_Count), 32'd0);
    chk({tag, "_full"}, 32'(bus.o_TX_Full), 32'd0);
    chk({tag, "_new"}, 32'(bus.o_New_Data), 32'd0);
    chk({tag, "_rxe"}, 32'(bus.o_RX_Empty), 32'd1);
    chk({tag, "_txo"}, 32'(bus.o_TX_Overflow), 32'd0);
    chk({tag, "_rxo"}, 32'(bus.o_RX_Overflow), 32'd0);
  endtask

  initial begin
    bus.i_TX_Data    = '0;
    bus.i_TX_Write   = 0;
    bus.i_LD_SR      = 0;
    bus.i_LD_R       = 0;
    bus.i_RX_SR_Data = '0;
    bus.i_RX_Read    = 0;
    bus.i_Clr_Err    = 0;
    model_reset();
    #1 check_reset_values("por");
    @(negedge clk);
    rst = 0;
    tick();

    // Head stays put while the load level is held; one pop on its fall.
    tick(1, 8'hA5);
    tick(1, 8'h3C);
    bus.i_LD_SR = 1;
    repeat (5) begin
      tick();
      chk("hold_sr", 32'(bus.o_SR_Data), 32'h A5);
    end
    bus.i_LD_SR = 0;
    tick();
    chk("drop_sr", 32'(bus.o_SR_Data), 32'h3C);
    chk("drop_cnt", 32'(bus.o_TX_Count), 32'd1);
    bus.i_LD_SR = 1; tick();
    bus.i_LD_SR = 0; tick();
    chk("drained", 32'(bus.o_New_Data), 32'd0);

    // Overfill the TX queue, then clear the sticky flag.
    for (int i = 0; i <= DEPTH; i++) tick(1, DATA_W'(8'h10 + i));
    chk("ovf_full", 32'(bus.o_TX_Full), 32'd1);
    chk("ovf_flag", 32'(bus.o_TX_Overflow), 32'd1);
    tick(0, '0, 0, 1);
    chk("ovf_clr", 32'(bus.o_TX_Overflow), 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      chk("ovf_order", 32'(bus.o_SR_Data), 32'(8'h10 + i));
      bus.i_LD_SR = 1; tick();
      bus.i_LD_SR = 0; tick();
    end

    // One capture for a multi-cycle receive load.
    bus.i_RX_SR_Data = 8'h5A;
    bus.i_LD_R = 1;
    repeat (3) tick();
    bus.i_LD_R = 0;
    tick();
    chk("cap_data", 32'(bus.o_RX_Data), 32'h5A);
    chk("cap_nempty", 32'(bus.o_RX_Empty), 32'd0);
    tick(0, '0, 1);
    chk("cap_read", 32'(bus.o_RX_Empty), 32'd1);

    // Full RX queue: capture alongside a read is accepted, alone it overflows.
    for (int i = 0; i < DEPTH; i++) begin
      bus.i_RX_SR_Data = DATA_W'(8'h60 + i);
      bus.i_LD_R = 1; tick();
      bus.i_LD_R = 0; tick();
    end
    bus.i_RX_SR_Data = 8'hEE;
    bus.i_LD_R = 1;
    tick(0, '0, 1);
    bus.i_LD_R = 0;
    tick();
    chk("rxf_noovf", 32'(bus.o_RX_Overflow), 32'd0);
    chk("rxf_head", 32'(bus.o_RX_Data), 32'h61);
    bus.i_RX_SR_Data = 8'hDD;
    bus.i_LD_R = 1; tick();
    bus.i_LD_R = 0; tick();
    chk("rxf_ovf", 32'(bus.o_RX_Overflow), 32'd1);
    tick(0, '0, 0, 1);
    for (int i = 0; i < DEPTH; i++) tick(0, '0, 1);
    chk("rxf_drain", 32'(bus.o_RX_Empty), 32'd1);

    // Stream enough words through to wrap the pointers twice.
    for (int i = 0; i < 2 * DEPTH + 1; i++) begin
      tick(1, DATA_W'(8'hC0 + i));
      chk("wrap_head", 32'(bus.o_SR_Data), 32'(8'hC0 + i));
      bus.i_LD_SR = 1; tick();
      bus.i_LD_SR = 0; tick();
    end
    chk("wrap_end", 32'(bus.o_New_Data), 32'd0);

    // Asynchronous reset mid-transfer; levels held across release must not act.
    for (int i = 0; i < 3; i++) tick(1, DATA_W'(8'h70 + i));
    bus.i_LD_SR = 1;
    bus.i_RX_SR_Data = 8'h99;
    bus.i_LD_R = 1;
    tick();
    #2 rst = 1;
    #1 check_reset_values("arst");
    model_reset();
    @(negedge clk);
    rst = 0;
    tick();
    tick();
    chk("arst_nocap", 32'(bus.o_RX_Empty), 32'd1);
    bus.i_LD_SR = 0;
    bus.i_LD_R  = 0;
    tick();
    chk("arst_cnt", 32'(bus.o_TX_Count), 32'd0);

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 2) == 0) bus.i_LD_SR = ~bus.i_LD_SR;
      if ($urandom_range(0, 2) == 0) bus.i_LD_R  = ~bus.i_LD_R;
      bus.i_RX_SR_Data = DATA_W'($urandom);
      tick($urandom_range(0, 2) != 0, DATA_W'($urandom),
           $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/spi_master_buffer.md
SPI_MASTER_BUFFER -- requirements
Module: spi_master_buffer

Parameters
REQ-001 DATA_W, default 8, word width of TX/RX data and shift-register parallel ports.
REQ-002 DEPTH, default 4, entries per FIFO; power of two, >=2; CNT_W = log2(DEPTH)+1.

Interface
REQ-003 i_clk  input  1  sole clock, rising-edge.
REQ-004 i_rst  input  1  reset, asynchronous, active-high.
REQ-005 i_TX_Data  input  DATA_W  word to queue for transmission.
REQ-006 i_TX_Write  input  1  one-cycle write strobe for i_TX_Data.
REQ-007 o_TX_Full  output  1  TX FIFO holds DEPTH words.
REQ-008 o_TX_Count  output  CNT_W  TX FIFO occupancy.
REQ-009 o_SR_Data  output  DATA_W  TX FIFO head word, parallel-load value for the SPI shift register.
REQ-010 o_New_Data  output  1  TX FIFO non-empty; drives the master FSM i_New_Data.
REQ-011 i_LD_SR  input  1  master FSM load-shift-register level.
REQ-012 i_LD_R  input  1  master FSM load-receive level.
REQ-013 i_RX_SR_Data  input  DATA_W  shift-register parallel contents (received word).
REQ-014 o_RX_Data  output  DATA_W  RX FIFO head word.
REQ-015 o_RX_Empty  output  1  RX FIFO holds no words.
REQ-016 i_RX_Read  input  1  one-cycle pop strobe for RX FIFO.
REQ-017 o_TX_Overflow  output  1  sticky: write attempted while TX full.
REQ-018 o_RX_Overflow  output  1  sticky: capture attempted while RX full.
REQ-019 i_Clr_Err  input  1  clears both sticky flags.

Function
REQ-020 TX FIFO: circular buffer, separate read/write pointers of log2(DEPTH) bits wrapping DEPTH-1 -> 0, count register CNT_W bits.
REQ-021 o_SR_Data = TX head combinationally (show-ahead); stable for the whole time i_LD_SR is high.
REQ-022 o_New_Data = (TX count != 0); o_TX_Full = (TX count == DEPTH).
REQ-023 TX pop on i_LD_SR falling edge only (registered prior value 1, current 0), if count != 0; pop with empty FIFO is ignored, no error.
REQ-024 i_LD_SR held high N cycles produces exactly one pop.
REQ-025 TX write: accepted if i_TX_Write and not o_TX_Full (full evaluated pre-pop same cycle); else word dropped, o_TX_Overflow set.
REQ-026 Simultaneous TX write and pop with 0<count<DEPTH: both performed, count unchanged.
REQ-027 RX capture on i_LD_R rising edge only (registered prior 0, current 1): i_RX_SR_Data sampled that cycle and written to RX FIFO; one capture per high period.
REQ-028 RX capture when RX full: word dropped, o_RX_Overflow set, unless i_RX_Read same cycle, then both performed, no overflow.
REQ-029 i_RX_Read with o_RX_Empty high ignored; o_RX_Data = RX head combinationally.
REQ-030 i_LD_SR and i_LD_R high together (RELOAD) processed independently.
REQ-031 i_Clr_Err clears sticky flags; if a set condition occurs the same cycle, set wins.
REQ-032 Edge-detect registers and pointers fully synchronous to i_clk apart from reset.

Reset
REQ-033 i_rst high: pointers, counts, edge-detect registers, sticky flags to 0 immediately; o_New_Data=0, o_TX_Full=0, o_TX_Count=0, o_RX_Empty=1, o_TX_Overflow=0, o_RX_Overflow=0.
REQ-034 Storage array not reset; o_SR_Data/o_RX_Data undefined-content-but-ignored while empty.
REQ-035 Reset mid-transfer (i_LD_SR or i_LD_R high): no pop or capture on the first clock after release even if level is already high/low.

Verification
REQ-036 Write 0xA5,0x3C; hold i_LD_SR 5 cycles then drop -> o_SR_Data=0xA5 throughout, one pop after drop, o_SR_Data=0x3C, o_TX_Count=1.
REQ-037 Write DEPTH+1 words back-to-back -> o_TX_Full=1 after DEPTH, last word dropped, o_TX_Overflow=1; i_Clr_Err -> 0.
REQ-038 i_RX_SR_Data=0x5A, i_LD_R high 3 cycles -> one RX entry, o_RX_Data=0x5A, o_RX_Empty=0; i_RX_Read -> o_RX_Empty=1.
REQ-039 Fill RX FIFO, capture with i_RX_Read same cycle -> no overflow, count stays DEPTH; capture without read -> o_RX_Overflow=1.
REQ-040 Push/pop 2*DEPTH+1 words in order -> pointer wrap, data order preserved, o_New_Data=0 at end.
REQ-041 Assert i_rst with 3 TX words queued and i_LD_SR high -> all outputs at reset values asynchronously; no pop after release.
